output_io_pulser: RTL

Avalon-MM slave driving a parallel output port; the write-side counterpart of the input IO edge-capture PIO on the same interconnect.
- Holds a level register with atomic set/clear addresses.
- Provides a one-shot pulse engine that inverts selected output bits for a programmed number of clocks.
- Sits on the testbench_ls interconnect and drives DUT control lines, such as strobes and enables, from the Nios software.

---
 rtl/output_io_pulser.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/output_io_pulser.sv
// Avalon-MM output PIO: level register with atomic set/clear, plus a one-shot pulse
// engine that inverts masked bits for PULSE_WIDTH clocks. Optional irq via OUTPIO_PULSE_IRQ_EN.
module output_io_pulser #(
  parameter int                 WIDTH       = 8,
  parameter logic [WIDTH-1:0]   RESET_VALUE = {WIDTH{1'b0}},
  parameter int                 PW_BITS     = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [WIDTH-1:0]  out_port
`ifdef OUTPIO_PULSE_IRQ_EN
  ,
  output logic              irq
`endif
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  localparam logic [2:0]         ADDR_DATA   = 3'd0;
  localparam logic [2:0]         ADDR_PW     = 3'd1;
  localparam logic [2:0]         ADDR_PULSE  = 3'd2;
  localparam logic [2:0]         ADDR_STATUS = 3'd3;
  localparam logic [2:0]         ADDR_SET    = 3'd4;
  localparam logic [2:0]         ADDR_CLR    = 3'd5;
  localparam logic [PW_BITS-1:0] CNT_ONE     = PW_BITS'(1);
  localparam logic [PW_BITS-1:0] CNT_ZERO    = {PW_BITS{1'b0}};
  localparam logic [WIDTH-1:0]   MASK_ZERO   = {WIDTH{1'b0}};

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     data_q, data_d;
  logic [PW_BITS-1:0]   pw_q, pw_d;
  logic [WIDTH-1:0]     mask_q, mask_d;
  logic [PW_BITS-1:0]   cnt_q, cnt_d;
  logic                 done_q, done_d;
  logic                 irq_mask_q, irq_mask_d;
  logic [31:0]          readdata_q, readdata_d;
  logic                 wr_s;
  logic                 busy_s;
  logic [WIDTH-1:0]     wd_mask_s;
  logic                 unused_wd_s;

  assign wr_s        = chipselect & ~write_n;
  assign busy_s      = (state_q == ST_ACTIVE);
  assign wd_mask_s   = writedata[WIDTH-1:0];
  assign unused_wd_s = ^writedata;

  // Register writes, pulse FSM next state and done/irq_mask updates.
  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    pw_d       = pw_q;
    mask_d     = mask_q;
    cnt_d      = cnt_q;
    done_d     = done_q;
    irq_mask_d = irq_mask_q;

    if (wr_s) begin
      case (address)
        ADDR_DATA:   data_d = wd_mask_s;
        ADDR_PW:     pw_d   = writedata[PW_BITS-1:0];
        ADDR_SET:    data_d = data_q | wd_mask_s;
        ADDR_CLR:    data_d = data_q & ~wd_mask_s;
        ADDR_STATUS: begin
          if (writedata[1]) begin
            done_d = 1'b0;
          end else begin
            done_d = done_q;
          end
`ifdef OUTPIO_PULSE_IRQ_EN
          irq_mask_d = writedata[2];
`else
          irq_mask_d = 1'b0;
`endif
        end
        default: data_d = data_q;
      endcase
    end else begin
      data_d = data_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (wr_s && (address == ADDR_PULSE) && (wd_mask_s != MASK_ZERO)) begin
          state_d = ST_ACTIVE;
          mask_d  = wd_mask_s;
          cnt_d   = (pw_q == CNT_ZERO) ? CNT_ONE : pw_q;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        // Completion overrides a same-cycle W1C of done.
        if (cnt_q == CNT_ONE) begin
          state_d = ST_IDLE;
          mask_d  = MASK_ZERO;
          cnt_d   = CNT_ZERO;
          done_d  = 1'b1;
        end else begin
          cnt_d   = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        mask_d  = MASK_ZERO;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // Read mux, sampled every clock regardless of chipselect.
  always_comb begin
    readdata_d = 32'd0;
    case (address)
      ADDR_DATA:   readdata_d[WIDTH-1:0]   = data_q;
      ADDR_PW:     readdata_d[PW_BITS-1:0] = pw_q;
      ADDR_PULSE:  readdata_d[WIDTH-1:0]   = mask_q;
      ADDR_STATUS: readdata_d[2:0]         = {irq_mask_q, done_q, busy_s};
      default:     readdata_d              = 32'd0;
    endcase
  end

  // State and register storage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      data_q     <= RESET_VALUE;
      pw_q       <= CNT_ONE;
      mask_q     <= MASK_ZERO;
      cnt_q      <= CNT_ZERO;
      done_q     <= 1'b0;
      irq_mask_q <= 1'b0;
      readdata_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      pw_q       <= pw_d;
      mask_q     <= mask_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      irq_mask_q <= irq_mask_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign out_port = data_q ^ (busy_s ? mask_q : MASK_ZERO);

`ifdef OUTPIO_PULSE_IRQ_EN
  logic irq_q;

  // Interrupt lags done/irq_mask by one clock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= done_q & irq_mask_q;
    end
  end

  assign irq = irq_q;
`endif

endmodule
